// File: rtl/smi_mem_lib_read_burst_segmenter.sv
// Read-burst segmenter: splits one (addr, len) read into SegmentSize-aligned segment commands
// and merges their in-order completion status into a single done report.
module smi_mem_lib_read_burst_segmenter #(
    parameter int WordBytes      = 8,
    parameter int SegmentSize    = 32,
    parameter int BoundaryBytes  = 4096,
    parameter int MaxOutstanding = 4,
    parameter bit AbortOnError   = 1'b1,
    parameter int LenWidth       = 32,
    localparam int SLW           = $clog2(SegmentSize) + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                paramsValid,
    input  logic [63:0]         paramAddr,
    input  logic [LenWidth-1:0] paramLen,
    input  logic [7:0]          paramOpts,
    output logic                paramsStop,
    output logic                segValid,
    output logic [63:0]         segAddr,
    output logic [SLW-1:0]      segLen,
    output logic [7:0]          segOpts,
    input  logic                segStop,
    input  logic                segDoneValid,
    input  logic                segDoneOk,
    output logic                segDoneStop,
    output logic                doneValid,
    output logic                doneStatusOk,
    output logic [LenWidth-1:0] doneWordCount,
    input  logic                doneStop
);

    localparam int WordShift = $clog2(WordBytes);
    localparam int WA        = 64 - WordShift;
    // Clamp the segment so it can never straddle a boundary even if misconfigured.
    localparam int SegWords  = (SegmentSize * WordBytes <= BoundaryBytes) ? SegmentSize
                                                                         : BoundaryBytes / WordBytes;
    localparam int OW        = $clog2(MaxOutstanding + 1);
    localparam int PW        = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    localparam logic [SLW-1:0] SegW    = SLW'(SegWords);
    localparam logic [WA-1:0]  SegMask = WA'(SegWords - 1);
    localparam logic [OW-1:0]  MaxOut  = OW'(MaxOutstanding);
    localparam logic [PW-1:0]  LastPtr = PW'(MaxOutstanding - 1);

    typedef enum logic [2:0] {Idle, Setup, Issue, Drain, Done} stateT;

    stateT               state, stateNext;
    logic [WA-1:0]       wordAddr;
    logic [LenWidth-1:0] remaining, remainingNext;
    logic [7:0]          opts;
    logic [SLW-1:0]      curLen, firstLen, nextLen, roomWords;
    logic                segValidReg, segValidNext;
    logic                ok, aborted, abortedNext;
    logic [LenWidth-1:0] count;
    logic [OW-1:0]       outstanding, outstandingNext;
    logic [SLW-1:0]      lenFifo [MaxOutstanding];
    logic [PW-1:0]       wrPtr, rdPtr;
    logic                reqAccept, segAccept, statusWindow, statusAccept, doneAccept;
    logic                unusedAddrBits;

    assign unusedAddrBits = ^paramAddr[WordShift-1:0];

    assign paramsStop    = (state != Idle);
    assign segValid      = segValidReg;
    assign segAddr       = {wordAddr, {WordShift{1'b0}}};
    assign segLen        = curLen;
    assign segOpts       = opts;
    // Status is only held off when it arrives with nothing outstanding.
    assign segDoneStop   = segDoneValid & ~statusWindow;
    assign doneValid     = (state == Done);
    assign doneStatusOk  = ok;
    assign doneWordCount = count;

    always_comb begin
        reqAccept    = paramsValid && (state == Idle);
        segAccept    = segValidReg && !segStop;
        statusWindow = ((state == Issue) || (state == Drain)) && (outstanding != '0);
        statusAccept = segDoneValid && statusWindow;
        doneAccept   = (state == Done) && !doneStop;

        remainingNext   = segAccept ? remaining - LenWidth'(curLen) : remaining;
        outstandingNext = outstanding;
        if (segAccept && !statusAccept) begin
            outstandingNext = outstanding + 1'b1;
        end else if (!segAccept && statusAccept) begin
            outstandingNext = outstanding - 1'b1;
        end
        abortedNext = aborted || (AbortOnError && statusAccept && !segDoneOk);

        roomWords = SegW - SLW'(wordAddr & SegMask);
        firstLen  = (remaining < LenWidth'(roomWords)) ? remaining[SLW-1:0] : roomWords;
        nextLen   = (remainingNext < LenWidth'(SegW)) ? remainingNext[SLW-1:0] : SegW;

        stateNext    = state;
        segValidNext = segValidReg;
        case (state)
            Idle: begin
                if (reqAccept) stateNext = Setup;
            end
            Setup: begin
                segValidNext = (remaining != '0);
                stateNext    = (remaining == '0) ? Done : Issue;
            end
            Issue: begin
                // A raised segValid is held until taken; abort only blocks new ones.
                if (!segValidReg || segAccept) begin
                    segValidNext = (remainingNext != '0) && (outstandingNext < MaxOut) && !abortedNext;
                end
                if (!segValidReg && ((remaining == '0) || aborted)) stateNext = Drain;
            end
            Drain: begin
                if (outstanding == '0) stateNext = Done;
            end
            Done: begin
                if (doneAccept) stateNext = Idle;
            end
            default: stateNext = Idle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= Idle;
            segValidReg <= 1'b0;
        end else begin
            state       <= stateNext;
            segValidReg <= segValidNext;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wordAddr    <= '0;
            remaining   <= '0;
            opts        <= '0;
            curLen      <= '0;
            ok          <= 1'b1;
            aborted     <= 1'b0;
            count       <= '0;
            outstanding <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else begin
            outstanding <= outstandingNext;
            aborted     <= abortedNext;
            if (reqAccept) begin
                wordAddr  <= paramAddr[63:WordShift];
                remaining <= paramLen;
                opts      <= paramOpts;
            end
            if (state == Setup) begin
                curLen  <= firstLen;
                ok      <= 1'b1;
                aborted <= 1'b0;
                count   <= '0;
            end
            if (segAccept) begin
                wordAddr  <= wordAddr + WA'(curLen);
                remaining <= remainingNext;
                curLen    <= nextLen;
                wrPtr     <= (wrPtr == LastPtr) ? '0 : wrPtr + 1'b1;
            end
            if (statusAccept) begin
                rdPtr <= (rdPtr == LastPtr) ? '0 : rdPtr + 1'b1;
                ok    <= ok & segDoneOk;
                if (ok && segDoneOk) count <= count + LenWidth'(lenFifo[rdPtr]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (segAccept) lenFifo[wrPtr] <= curLen;
    end

endmodule

// File: tb/tb_smi_mem_lib_read_burst_segmenter.sv
// Directed testbench for smi_mem_lib_read_burst_segmenter with default parameters
// (8-byte words, 32-word segments, 4 KiB boundary, 4 outstanding, abort on error).
module tb_smi_mem_lib_read_burst_segmenter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        paramsValid;
    logic [63:0] paramAddr;
    logic [31:0] paramLen;
    logic [7:0]  paramOpts;
    logic        paramsStop;
    logic        segValid;
    logic [63:0] segAddr;
    logic [5:0]  segLen;
    logic [7:0]  segOpts;
    logic        segStop;
    logic        segDoneValid;
    logic        segDoneOk;
    logic        segDoneStop;
    logic        doneValid;
    logic        doneStatusOk;
    logic [31:0] doneWordCount;
    logic        doneStop;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [63:0] logAddr [16];
    logic [5:0]  logLen [16];
    logic [7:0]  logOpts;
    int          nSeg, firstSegIter, doneIter, riseAfterAbort, leftPending, n4;
    bit          gotDone;
    logic        obsOk;
    logic [31:0] obsCount;

    always #5 clk = ~clk;

    smi_mem_lib_read_burst_segmenter dut (
        .clk(clk),
        .rstn(rstn),
        .paramsValid(paramsValid),
        .paramAddr(paramAddr),
        .paramLen(paramLen),
        .paramOpts(paramOpts),
        .paramsStop(paramsStop),
        .segValid(segValid),
        .segAddr(segAddr),
        .segLen(segLen),
        .segOpts(segOpts),
        .segStop(segStop),
        .segDoneValid(segDoneValid),
        .segDoneOk(segDoneOk),
        .segDoneStop(segDoneStop),
        .doneValid(doneValid),
        .doneStatusOk(doneStatusOk),
        .doneWordCount(doneWordCount),
        .doneStop(doneStop)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request; returns at the cycle after acceptance (the Setup cycle).
    task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] len, input logic [7:0] opts);
        bit taken;
        taken       = 1'b0;
        paramsValid = 1'b1;
        paramAddr   = addr;
        paramLen    = len;
        paramOpts   = opts;
        for (int i = 0; i < 50 && !taken; i++) begin
            #1;
            taken = !paramsStop;
            @(posedge clk);
            #1;
        end
        paramsValid = 1'b0;
        if (!taken) checkOutput("req_timeout", 64'd0, 64'd1);
    endtask

    // Plays the downstream core: accepts segments, returns statuses in order, takes done.
    task automatic serviceLoop(input int startPending, input int startStatusIdx, input int failIdx,
                               input bit randomBp);
        int pending, statusIdx;
        bit prevSegValid, abortSeen, statusTaken;
        pending = startPending;
        statusIdx = startStatusIdx;
        prevSegValid = 1'b0;
        abortSeen = 1'b0;
        statusTaken = 1'b0;
        nSeg = 0;
        firstSegIter = -1;
        doneIter = -1;
        riseAfterAbort = 0;
        gotDone = 1'b0;
        for (int it = 0; it < 2000 && !gotDone; it++) begin
            if (statusTaken) begin
                segDoneValid = 1'b0;
                statusTaken  = 1'b0;
            end
            segStop  = randomBp ? ($urandom_range(0, 2) == 0) : 1'b0;
            doneStop = randomBp ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (!segDoneValid && pending > 0 && (!randomBp || $urandom_range(0, 1) == 1)) begin
                segDoneValid = 1'b1;
                segDoneOk    = (statusIdx != failIdx);
            end
            #1;
            if (abortSeen && segValid && !prevSegValid) riseAfterAbort++;
            prevSegValid = segValid;
            if (segValid && !segStop) begin
                if (nSeg < 16) begin
                    logAddr[nSeg] = segAddr;
                    logLen[nSeg]  = segLen;
                end
                if (nSeg == 0) begin
                    logOpts      = segOpts;
                    firstSegIter = it;
                end
                nSeg++;
                pending++;
            end
            if (segDoneValid && !segDoneStop) begin
                if (!segDoneOk) abortSeen = 1'b1;
                pending--;
                statusIdx++;
                statusTaken = 1'b1;
            end
            if (doneValid && !doneStop) begin
                gotDone  = 1'b1;
                doneIter = it;
                obsOk    = doneStatusOk;
                obsCount = doneWordCount;
            end
            @(posedge clk);
            #1;
        end
        if (statusTaken) segDoneValid = 1'b0;
        segStop     = 1'b0;
        doneStop    = 1'b0;
        leftPending = pending;
        if (!gotDone) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic checkSeg(input string tag, input int idx, input logic [63:0] addr, input logic [5:0] len);
        checkOutput($sformatf("%s_addr%0d", tag, idx), logAddr[idx], addr);
        checkOutput($sformatf("%s_len%0d", tag, idx), {58'd0, logLen[idx]}, {58'd0, len});
    endtask

    task automatic checkDone(input string tag, input int segs, input logic ok, input logic [31:0] cnt);
        checkOutput({tag, "_nseg"}, segs, nSeg);
        checkOutput({tag, "_ok"}, {63'd0, obsOk}, {63'd0, ok});
        checkOutput({tag, "_count"}, {32'd0, obsCount}, {32'd0, cnt});
        checkOutput({tag, "_drained"}, leftPending, 0);
    endtask

    initial begin
        rstn = 1'b0;
        paramsValid = 1'b0;
        paramAddr = '0;
        paramLen = '0;
        paramOpts = '0;
        segStop = 1'b0;
        segDoneValid = 1'b0;
        segDoneOk = 1'b1;
        doneStop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_segValid", {63'd0, segValid}, 64'd0);
        checkOutput("rst_doneValid", {63'd0, doneValid}, 64'd0);
        checkOutput("rst_paramsStop", {63'd0, paramsStop}, 64'd0);
        checkOutput("rst_segDoneStop", {63'd0, segDoneStop}, 64'd0);
        checkOutput("rst_doneStatusOk", {63'd0, doneStatusOk}, 64'd1);
        checkOutput("rst_doneWordCount", {32'd0, doneWordCount}, 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Unsolicited status while idle is held off.
        segDoneValid = 1'b1;
        #1;
        checkOutput("unsolicited_stop", {63'd0, segDoneStop}, 64'd1);
        @(posedge clk);
        #1;
        segDoneValid = 1'b0;

        // Aligned 64-word read: two full segments, first segValid two cycles after accept.
        applyStimulus(64'h0, 32'd64, 8'hA5);
        checkOutput("t1_setup_segValid", {63'd0, segValid}, 64'd0);
        serviceLoop(0, 0, -1, 1'b0);
        checkOutput("t1_latency", firstSegIter, 1);
        checkOutput("t1_opts", {56'd0, logOpts}, 64'hA5);
        checkSeg("t1", 0, 64'h000, 6'd32);
        checkSeg("t1", 1, 64'h100, 6'd32);
        checkDone("t1", 2, 1'b1, 32'd64);

        // Start near a 4 KiB boundary: short first segment, second starts on the boundary.
        applyStimulus(64'h0FF0, 32'd10, 8'h00);
        serviceLoop(0, 0, -1, 1'b0);
        checkSeg("t2", 0, 64'h0FF0, 6'd2);
        checkSeg("t2", 1, 64'h1000, 6'd8);
        checkDone("t2", 2, 1'b1, 32'd10);

        // Zero length: no segments, done two cycles after accept.
        applyStimulus(64'h1234, 32'd0, 8'h00);
        serviceLoop(0, 0, -1, 1'b0);
        checkOutput("t3_done_latency", doneIter, 1);
        checkDone("t3", 0, 1'b1, 32'd0);

        // Outstanding limit: four segments with no statuses, then one return frees one slot.
        applyStimulus(64'h0, 32'd256, 8'h00);
        n4 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (segValid && !segStop) n4++;
            @(posedge clk);
            #1;
        end
        checkOutput("t4_issued_at_limit", n4, 4);
        checkOutput("t4_segValid_held", {63'd0, segValid}, 64'd0);
        segDoneValid = 1'b1;
        segDoneOk = 1'b1;
        #1;
        checkOutput("t4_status_ready", {63'd0, segDoneStop}, 64'd0);
        @(posedge clk);
        #1;
        segDoneValid = 1'b0;
        n4 = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (segValid && !segStop) n4++;
            @(posedge clk);
            #1;
        end
        checkOutput("t4_released_one", n4, 1);
        checkOutput("t4_segValid_after", {63'd0, segValid}, 64'd0);
        serviceLoop(4, 1, -1, 1'b0);
        checkSeg("t4", 0, 64'h500, 6'd32);
        checkSeg("t4", 2, 64'h700, 6'd32);
        checkDone("t4", 3, 1'b1, 32'd256);

        // Abort: second status fails; only the first segment's words count.
        applyStimulus(64'h0, 32'd256, 8'h00);
        serviceLoop(0, 0, 1, 1'b0);
        checkOutput("t5_no_new_seg", riseAfterAbort, 0);
        checkDone("t5", 3, 1'b0, 32'd32);

        // Reset while a segment is stalled by segStop.
        applyStimulus(64'h0, 32'd64, 8'h00);
        segStop = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_pre_segValid", {63'd0, segValid}, 64'd1);
        rstn = 1'b0;
        #1;
        checkOutput("t6_rst_segValid", {63'd0, segValid}, 64'd0);
        checkOutput("t6_rst_paramsStop", {63'd0, paramsStop}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        segStop = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(64'h0, 32'd64, 8'h00);
        serviceLoop(0, 0, -1, 1'b0);
        checkSeg("t6", 0, 64'h000, 6'd32);
        checkSeg("t6", 1, 64'h100, 6'd32);
        checkDone("t6", 2, 1'b1, 32'd64);

        // Address wrap at 2^64.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFF0, 32'd4, 8'h3C);
        serviceLoop(0, 0, -1, 1'b0);
        checkSeg("wrap", 0, 64'hFFFF_FFFF_FFFF_FFF0, 6'd2);
        checkSeg("wrap", 1, 64'h0, 6'd2);
        checkDone("wrap", 2, 1'b1, 32'd4);

        // Random backpressure on every handshake.
        applyStimulus(64'h0FF0, 32'd100, 8'h11);
        serviceLoop(0, 0, -1, 1'b1);
        checkSeg("rnd", 0, 64'h0FF0, 6'd2);
        checkSeg("rnd", 1, 64'h1000, 6'd32);
        checkSeg("rnd", 2, 64'h1100, 6'd32);
        checkSeg("rnd", 3, 64'h1200, 6'd32);
        checkSeg("rnd", 4, 64'h1300, 6'd2);
        checkDone("rnd", 5, 1'b1, 32'd100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
